// File: rtl/block_config_bank.sv
// block_config_bank: multi-LUT configuration memory. It fills a shadow image from a
// valid/ready word stream and commits the whole image atomically to the active
// tables. Each LUT is read combinationally from the active table.
// Optional feature macro CFG_READBACK_EN: streams the active image back out on rb_data.
module block_config_bank #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned NUM_LUTS  = 2,
  parameter int unsigned WORD_BITS = 8
) (
  input  logic                          cclk,
  input  logic                          crst_n,
  input  logic [NUM_LUTS*ADDR_BITS-1:0] addr,
  output logic [NUM_LUTS-1:0]           out,
  input  logic                          cen,
  input  logic [WORD_BITS-1:0]          cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err
`ifdef CFG_READBACK_EN
  ,
  input  logic                          rb_req,
  output logic [WORD_BITS-1:0]          rb_data,
  output logic                          rb_valid
`endif
);

  localparam int unsigned MEM_SIZE   = 1 << ADDR_BITS;
  localparam int unsigned TOTAL_BITS = NUM_LUTS * MEM_SIZE;
  localparam int unsigned NWORDS     = TOTAL_BITS / WORD_BITS;
  localparam int unsigned CNT_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned LAST_WORD  = NWORDS - 1;

  // Reject configurations where the image does not split into whole words
  if ((TOTAL_BITS % WORD_BITS) != 0) begin : g_bad_word_bits
    $error("block_config_bank: NUM_LUTS*MEM_SIZE must be divisible by WORD_BITS");
  end

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_READBACK = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [TOTAL_BITS-1:0]   shadow_q;
  logic [TOTAL_BITS-1:0]   mem_q;
  logic                    err_q;

  logic                    accept;
  logic                    cnt_clr;
  logic                    cnt_inc;
  logic                    commit;
  logic                    err_d;

  // Ready only while loading, and dropped the moment the session enable goes away
  assign cfg_ready = (state_q == ST_LOAD) && cen;
  assign cfg_busy  = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
  assign cfg_done  = (state_q == ST_COMMIT);
  assign cfg_err   = err_q;

`ifdef CFG_READBACK_EN
  assign rb_valid = (state_q == ST_READBACK);
  assign rb_data  = mem_q[int'(cnt_q)*WORD_BITS +: WORD_BITS];
`endif

  // Next-state and per-cycle control decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (cen) begin
          state_d = ST_LOAD;
        end
`ifdef CFG_READBACK_EN
        else if (rb_req) begin
          state_d = ST_READBACK;
        end
`endif
      end
      ST_LOAD: begin
        if (!cen) begin
          // Abort: drop the partial image, active tables untouched
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
          err_d   = 1'b1;
        end else if (cfg_valid) begin
          accept = 1'b1;
          if (cnt_q == CNT_W'(LAST_WORD)) begin
            state_d = ST_COMMIT;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!cen) begin
          state_d = ST_IDLE;
        end
      end
`ifdef CFG_READBACK_EN
      ST_READBACK: begin
        if (cnt_q == CNT_W'(LAST_WORD)) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, word counter and abort pulse
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Shadow image: accepted word k lands at word slot k
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      shadow_q <= '0;
    end else if (accept) begin
      shadow_q[int'(cnt_q)*WORD_BITS +: WORD_BITS] <= cfg_data;
    end
  end

  // Active tables: replaced in one step from the complete shadow image
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      mem_q <= '0;
    end else if (commit) begin
      mem_q <= shadow_q;
    end
  end

  // Combinational per-LUT lookup from the active table
  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    logic [MEM_SIZE-1:0] lut_bits;
    assign lut_bits = mem_q[i*MEM_SIZE +: MEM_SIZE];
    assign out[i]   = lut_bits[addr[i*ADDR_BITS +: ADDR_BITS]];
  end

endmodule
